// File: rtl/spi_master_4094_if.sv
// spi_master_4094_if: request/status handshake plus the 4094 serial pins
// Signals: start_i/data_i/len_i request a transfer; busy_o/done_o/rdata_o report it;
//   sck_o/mosi_o/strobe_o drive the 4094 chain; miso_i returns from its last stage.
// Modports: master is the serial engine, slave is the requesting/chain side.
interface spi_master_4094_if #(
  parameter int MAX_BITS = 32
);
  logic                start_i;
  logic [MAX_BITS-1:0] data_i;
  logic [5:0]          len_i;
  logic                busy_o;
  logic                done_o;
  logic [MAX_BITS-1:0] rdata_o;
  logic                sck_o;
  logic                mosi_o;
  logic                strobe_o;
  logic                miso_i;
  modport master (
    input  start_i, data_i, len_i, miso_i,
    output busy_o, done_o, rdata_o, sck_o, mosi_o, strobe_o
  );
  modport slave (
    output start_i, data_i, len_i, miso_i,
    input  busy_o, done_o, rdata_o, sck_o, mosi_o, strobe_o
  );
endinterface

// File: rtl/spi_master_4094.sv
// spi_master_4094: serial master that shifts a word MSB-first into a CD4094 chain and strobes it
// Ports: CLK system clock (rising edge); reset_n asynchronous active-low reset;
//   bus (master modport): start_i/data_i/len_i request, busy_o/done_o/rdata_o status,
//   sck_o/mosi_o/strobe_o to the chain, miso_i from the chain's last stage.
module spi_master_4094 #(
  parameter int CLK_DIV  = 2,
  parameter int MAX_BITS = 32
) (
  input logic               CLK,
  input logic               reset_n,
  spi_master_4094_if.master bus
);
  typedef enum logic [2:0] {IDLE, SCK_LO, SCK_HI, GAP, STROBE, DONE} state_t;
  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  state_t              state_q, state_d;
  logic [7:0]          div_q, div_d;
  logic [5:0]          bits_q, bits_d;
  logic [MAX_BITS-1:0] tx_q, tx_d, rx_q, rx_d, rdata_q, rdata_d;
  logic                sck_q, sck_d, mosi_q, mosi_d, strobe_q, strobe_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                len_ok, tick;
  assign len_ok = bus.len_i != 6'd0 && 32'(bus.len_i) <= MAX_BITS;
  assign tick   = div_q == 8'd0;
  always_comb begin
    state_d = state_q;
    bits_d  = bits_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    mosi_d  = mosi_q;
    case (state_q)
      IDLE: if (bus.start_i) begin
        // left-justify so bit len-1 of the word sits in the MSB and shifts out first
        tx_d    = len_ok ? bus.data_i << (MAX_BITS - 32'(bus.len_i)) : '0;
        bits_d  = bus.len_i;
        rx_d    = '0;
        mosi_d  = len_ok ? tx_d[MAX_BITS-1] : mosi_q;
        state_d = len_ok ? SCK_LO : DONE;
      end
      SCK_LO: if (tick) begin
        // the rising SCK edge is the transition into SCK_HI, so miso is captured here
        rx_d    = {rx_q[MAX_BITS-2:0], bus.miso_i};
        state_d = SCK_HI;
      end
      SCK_HI: if (tick) begin
        bits_d  = bits_q - 6'd1;
        tx_d    = tx_q << 1;
        mosi_d  = bits_d != 6'd0 ? tx_q[MAX_BITS-2] : mosi_q;
        state_d = bits_d != 6'd0 ? SCK_LO : GAP;
      end
      GAP:     if (tick) state_d = STROBE;
      STROBE:  if (tick) state_d = DONE;
      default: state_d = IDLE;
    endcase
    // reload on every state change; hold at zero otherwise so CLK_DIV=1 never wraps
    div_d    = state_d != state_q ? DIV_LOAD : tick ? div_q : div_q - 8'd1;
    rdata_d  = state_d == DONE ? rx_d : rdata_q;
    sck_d    = state_d == SCK_HI;
    strobe_d = state_d == STROBE;
    busy_d   = state_d != IDLE;
    done_d   = state_d == DONE;
  end
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bits_q   <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      rdata_q  <= '0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bits_q   <= bits_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  assign bus.sck_o    = sck_q;
  assign bus.mosi_o   = mosi_q;
  assign bus.strobe_o = strobe_q;
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.rdata_o  = rdata_q;
endmodule
